seq_chunk_adder: RTL and testbench
==================================

Name: seq_chunk_adder

Overview:
- Multi-cycle add/subtract unit. Operands are parametrised at WIDTH bits and processed CHUNK bits per clock with a ripple carry between chunks.
- Generalises the fixed-width structural adders into one sequential, parametrised block with a start/done handshake, a subtract mode and signed-overflow detection.
- Used wherever a wide add is needed but a full-width single-cycle carry chain is too slow.

Parameters:
- WIDTH, 32, operand/result width in bits. Must be an integer multiple of CHUNK.
- CHUNK, 8, bits added per clock cycle. NCHUNK = WIDTH/CHUNK, and NCHUNK >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A; latched when start is accepted.
- b  input  WIDTH  operand B; latched when start is accepted.
- cin  input  1  carry-in; used only when sub=0.
- sub  input  1  0: s = a+b+cin. 1: s = a-b, computed as a+~b+1, with cin ignored. Latched with the operands.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; the result is valid.
- s  output  WIDTH  sum/difference.
- cout  output  1  carry out of the MSB. In subtract mode 1 means no borrow.
- ovf  output  1  two's-complement overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately):
  - State goes to IDLE.
  - busy=0, done=0, s=0, cout=0, ovf=0.
  - Internal operand, carry and index registers clear.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, done=0.
  - DONE: busy=0, done=1, lasts exactly one cycle.
- IDLE -> RUN: at edge T0 with start=1.
  - Latch a, then b or ~b, and sub.
  - Internal carry = sub ? 1 : cin.
  - idx = 0.
- RUN, at edges T1..TNCHUNK:
  - Compute chunk idx: {c, s[idx*CHUNK +: CHUNK]} = A_chunk + B_chunk + carry.
  - carry <= c; idx <= idx+1.
  - At the edge processing idx = NCHUNK-1:
    - cout <= c.
    - ovf <= (carry into bit WIDTH-1) XOR c.
    - State -> DONE.
- Latency: done is high in the cycle following edge T(NCHUNK), i.e. NCHUNK clocks after the start edge.
- DONE:
  - start=1 behaves exactly as IDLE -> RUN, so back-to-back operations run with one DONE cycle between them.
  - Otherwise the state goes to IDLE.
- s, cout, ovf:
  - Hold their values after DONE until the next accepted start.
  - During RUN, s is written chunk by chunk; it is valid only from the done cycle onward.
- start while in RUN: ignored. Operands on a, b, cin and sub may change freely after T0 without affecting the result.
- NCHUNK=1: RUN lasts one cycle; done is high one clock after start.
- Reset during RUN: the operation is aborted, done never asserts, and all outputs go to their reset values.
- Width rules:
  - The idx counter is sized to hold NCHUNK-1 (minimum 1 bit).
  - There is no wrap beyond NCHUNK-1; the DONE transition occurs at the final index.

Test Plan:
- Default parameters, sub=0, a=0x0000FFFF, b=0x00000001, cin=0 -> busy high T1..T4, done pulses after T4, s=0x00010000, cout=0, ovf=0. Checks the carry crossing the chunk boundary.
- sub=0, a=0xFFFFFFFF, b=0x00000000, cin=1 -> s=0x00000000, cout=1, ovf=0. Checks carry propagation through all 4 chunks.
- sub=0, a=0x7FFFFFFF, b=0x00000001, cin=0 -> s=0x80000000, cout=0, ovf=1. In a second run, sub=1, a=0x80000000, b=0x00000001 -> s=0x7FFFFFFF, cout=1, ovf=1.
- sub=1, a=0x00000005, b=0x00000007, cin=1 -> s=0xFFFFFFFE, cout=0 (borrow), ovf=0. Confirms cin is ignored in subtract mode.
- Start a=1, b=1 at T0, then at T2 pulse start with a=0xFFFFFFFF, b=0xFFFFFFFF -> the second start is ignored and the result is s=0x00000002. In a second run, drop rst_n low mid-cycle at T2 -> busy=0 and s=0 immediately, and done never asserts.
- WIDTH=16, CHUNK=16 -> done one clock after start. With start held high through the DONE cycle (a=0x1234, b=0x1111, then a=0xFFFF, b=0x0001), the results are 0x2345 and then 0x0000 with cout=1, and done pulses 2 clocks apart.

Source files
------------

// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/subtract unit. The operands are latched on start and
// added CHUNK bits per clock, least significant chunk first, with the carry
// rippled from one cycle to the next. It reports carry-out and
// two's-complement overflow and pulses done for one cycle when the result is ready.
module seq_chunk_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [WIDTH-1:0] a_reg;      // latched operand A
    logic [WIDTH-1:0] b_reg;      // latched operand B, already inverted for subtract
    logic [WIDTH-1:0] s_reg;
    logic             carry_reg;  // carry into the chunk selected by idx_reg
    logic             cout_reg;
    logic             ovf_reg;
    logic [IDXW-1:0]  idx_reg;

    logic             accept;     // a start request is taken this cycle
    logic             last;       // the current chunk is the most significant one
    logic [CHUNK-1:0] a_chunks [NCHUNK];
    logic [CHUNK-1:0] b_chunks [NCHUNK];
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_sum;
    logic             msb_carry_in;

    // Split the latched operands into per-chunk slices.
    genvar gi;
    generate
        for (gi = 0; gi < NCHUNK; gi++) begin : g_slice
            assign a_chunks[gi] = a_reg[gi*CHUNK +: CHUNK];
            assign b_chunks[gi] = b_reg[gi*CHUNK +: CHUNK];
        end
    endgenerate

    // Select the chunk currently being processed. Out-of-range indices map to zero.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_reg == IDXW'(i)) begin
                a_chunk = a_chunks[i];
                b_chunk = b_chunks[i];
            end
        end
    end

    // One chunk of the ripple add. The carry into the top bit of the chunk is
    // recovered from the sum bit and the two operand bits.
    assign chunk_sum    = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_reg};
    assign msb_carry_in = chunk_sum[CHUNK-1] ^ a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1];
    assign last         = (idx_reg == IDXW'(NCHUNK - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and status outputs. DONE accepts a new start just as IDLE does.
    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: latch the operands on accept, then add one chunk per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            s_reg     <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            idx_reg   <= '0;
        end else if (accept) begin
            a_reg     <= a;
            b_reg     <= sub ? ~b : b;
            carry_reg <= sub ? 1'b1 : cin;
            idx_reg   <= '0;
        end else if (state_reg == RUN) begin
            for (int i = 0; i < NCHUNK; i++) begin
                if (idx_reg == IDXW'(i)) begin
                    s_reg[i*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
                end
            end
            carry_reg <= chunk_sum[CHUNK];
            if (last) begin
                // The index stays at the final chunk rather than wrapping.
                cout_reg <= chunk_sum[CHUNK];
                ovf_reg  <= msb_carry_in ^ chunk_sum[CHUNK];
            end else begin
                idx_reg <= idx_reg + 1'b1;
            end
        end
    end

    assign s    = s_reg;
    assign cout = cout_reg;
    assign ovf  = ovf_reg;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Testbench for seq_chunk_adder. Two instances are exercised: 32/8 and 16/16.
module tb_seq_chunk_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    logic        start0 = 1'b0, cin0 = 1'b0, sub0 = 1'b0;
    logic [31:0] a0 = '0, b0 = '0;
    logic        busy0, done0, cout0, ovf0;
    logic [31:0] s0;

    logic        start1 = 1'b0, cin1 = 1'b0, sub1 = 1'b0;
    logic [15:0] a1 = '0, b1 = '0;
    logic        busy1, done1, cout1, ovf1;
    logic [15:0] s1;

    seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0), .cin(cin0), .sub(sub0),
        .busy(busy0), .done(done0), .s(s0), .cout(cout0), .ovf(ovf0)
    );

    seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1), .sub(sub1),
        .busy(busy1), .done(done1), .s(s1), .cout(cout1), .ovf(ovf1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit skip_busy = 1'b0;

    typedef struct {
        int              u;
        longint unsigned s;
        bit              cout;
        bit              ovf;
        int              cyc;
    } exp_t;

    exp_t sbq[$];

    function automatic int nch(input int u);
        return (u == 0) ? 4 : 1;
    endfunction

    function automatic int wid(input int u);
        return (u == 0) ? 32 : 16;
    endfunction

    // Reference: plain unsigned and signed integer arithmetic on the full operands.
    function automatic exp_t model(input int u, input longint unsigned av_in, input longint unsigned bv_in,
                                   input bit c, input bit sb);
        exp_t            e;
        int              w;
        longint unsigned mask, av, bv, full;
        longint          sa, sbs, res, maxv, minv;
        w    = wid(u);
        mask = (64'd1 << w) - 64'd1;
        av   = av_in & mask;
        bv   = bv_in & mask;
        sa   = longint'(av);
        if (av[w-1]) sa = sa - (longint'(1) << w);
        sbs  = longint'(bv);
        if (bv[w-1]) sbs = sbs - (longint'(1) << w);
        res  = sb ? (sa - sbs) : (sa + sbs + longint'(c));
        maxv = (longint'(1) << (w - 1)) - 1;
        minv = -(longint'(1) << (w - 1));
        full = sb ? (av - bv) : (av + bv + longint'(c));
        e.u    = u;
        e.s    = full & mask;
        e.cout = sb ? (av >= bv) : full[w];
        e.ovf  = (res > maxv) || (res < minv);
        e.cyc  = 0;
        return e;
    endfunction

    task automatic chk(input string nm, input longint unsigned got, input longint unsigned want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    // Monitor: checks busy every cycle and compares each done against the scoreboard.
    always @(negedge clk) begin
        exp_t            e;
        bit              eb, bz, dn, ac, ao;
        longint unsigned as;
        if (rst_n) begin
            for (int u = 0; u < 2; u++) begin
                bz = (u == 0) ? busy0 : busy1;
                dn = (u == 0) ? done0 : done1;
                as = (u == 0) ? longint'(s0) : longint'(s1);
                ac = (u == 0) ? cout0 : cout1;
                ao = (u == 0) ? ovf0 : ovf1;
                eb = 1'b0;
                if (sbq.size() > 0 && sbq[0].u == u && cyc >= sbq[0].cyc - nch(u) && cyc < sbq[0].cyc)
                    eb = 1'b1;
                if (!skip_busy) begin
                    checks++;
                    if (bz !== eb) begin
                        errors++;
                        $display("FAIL busy u%0d cyc %0d: got %b want %b", u, cyc, bz, eb);
                    end
                end
                if (dn === 1'b1) begin
                    checks++;
                    if (sbq.size() == 0 || sbq[0].u != u) begin
                        errors++;
                        $display("FAIL unexpected_done u%0d cyc %0d: got done=1 want done=0", u, cyc);
                    end else begin
                        e = sbq.pop_front();
                        $display("txn u%0d cyc %0d s=%0h cout=%b ovf=%b (exp s=%0h cout=%b ovf=%b cyc %0d)",
                                 u, cyc, as, ac, ao, e.s, e.cout, e.ovf, e.cyc);
                        if (as !== e.s || ac !== e.cout || ao !== e.ovf || cyc != e.cyc) begin
                            errors++;
                            $display("FAIL result u%0d: got s=%0h cout=%b ovf=%b cyc %0d want s=%0h cout=%b ovf=%b cyc %0d",
                                     u, as, ac, ao, cyc, e.s, e.cout, e.ovf, e.cyc);
                        end
                    end
                end
            end
            if (sbq.size() > 0 && cyc > sbq[0].cyc) begin
                e = sbq.pop_front();
                checks++;
                errors++;
                $display("FAIL timeout u%0d: got no done by cyc %0d want done at cyc %0d", e.u, cyc, e.cyc);
            end
        end
    end

    // Drive one start pulse (called just after a negedge); optionally record the expectation.
    task automatic issue(input int u, input logic [31:0] av, input logic [31:0] bv,
                         input logic c, input logic sb, input bit push);
        exp_t e;
        if (u == 0) begin
            a0 = av; b0 = bv; cin0 = c; sub0 = sb; start0 = 1'b1;
        end else begin
            a1 = av[15:0]; b1 = bv[15:0]; cin1 = c; sub1 = sb; start1 = 1'b1;
        end
        if (push) begin
            e = model(u, longint'(av), longint'(bv), c, sb);
            e.cyc = cyc + 1 + nch(u);
            sbq.push_back(e);
        end
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        // Inputs after the accepting edge must not influence the result.
        a0 = $urandom; b0 = $urandom; {cin0, sub0} = 2'($urandom);
        a1 = 16'($urandom); b1 = 16'($urandom); {cin1, sub1} = 2'($urandom);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic run_op(input int u, input logic [31:0] av, input logic [31:0] bv,
                          input logic c, input logic sb);
        int t;
        t = cyc + 1 + nch(u);
        issue(u, av, bv, c, sb, 1'b1);
        wait_cyc(t);
    endtask

    initial begin
        int t;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy0", longint'(busy0), 0);
        chk("rst_done0", longint'(done0), 0);
        chk("rst_s0",    longint'(s0),    0);
        chk("rst_cout0", longint'(cout0), 0);
        chk("rst_ovf0",  longint'(ovf0),  0);
        chk("rst_busy1", longint'(busy1), 0);
        chk("rst_s1",    longint'(s1),    0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors on the 32/8 instance.
        run_op(0, 32'h0000FFFF, 32'h00000001, 1'b0, 1'b0);
        @(negedge clk);
        run_op(0, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0);
        run_op(0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
        run_op(0, 32'h80000000, 32'h00000001, 1'b0, 1'b1);
        run_op(0, 32'h00000005, 32'h00000007, 1'b1, 1'b1);
        @(negedge clk);

        // A start arriving during RUN is ignored.
        t = cyc + 1 + nch(0);
        issue(0, 32'h1, 32'h1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        a0 = 32'hFFFFFFFF; b0 = 32'hFFFFFFFF; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_cyc(t);
        @(negedge clk);

        // Reset dropped part way through a run aborts it with no done.
        skip_busy = 1'b1;
        issue(0, $urandom, $urandom, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy0", longint'(busy0), 0);
        chk("abort_done0", longint'(done0), 0);
        chk("abort_s0",    longint'(s0),    0);
        chk("abort_cout0", longint'(cout0), 0);
        chk("abort_ovf0",  longint'(ovf0),  0);
        @(negedge clk);
        rst_n = 1'b1;
        skip_busy = 1'b0;
        repeat (6) @(negedge clk);

        // 16/16 instance: start held through the DONE cycle runs back to back.
        t = cyc;
        a1 = 16'h1234; b1 = 16'h1111; cin1 = 1'b0; sub1 = 1'b0; start1 = 1'b1;
        begin
            exp_t e;
            e = model(1, 64'h1234, 64'h1111, 1'b0, 1'b0);
            e.cyc = t + 2;
            sbq.push_back(e);
            @(negedge clk);
            a1 = 16'hFFFF; b1 = 16'h0001;
            @(negedge clk);
            e = model(1, 64'hFFFF, 64'h0001, 1'b0, 1'b0);
            e.cyc = t + 4;
            sbq.push_back(e);
        end
        @(negedge clk);
        start1 = 1'b0;
        wait_cyc(t + 4);
        @(negedge clk);

        // Randomised traffic with random gaps (zero gap means back to back).
        for (int i = 0; i < 40; i++) begin
            run_op(0, $urandom, $urandom, 1'($urandom), 1'($urandom));
            repeat ($urandom_range(2, 0)) @(negedge clk);
        end
        for (int i = 0; i < 20; i++) begin
            run_op(1, $urandom, $urandom, 1'($urandom), 1'($urandom));
            repeat ($urandom_range(2, 0)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000 want finish");
        $fatal(1);
    end

endmodule
